// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [1:0]  ALIGN_MASK     = 2'b11;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; the priority pointer names the port that wins a tie.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    port_t prio_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prio_q <= PORT0;
        end else if (advance && (grant != 2'b00)) begin
            // The port just served yields the next tie.
            prio_q <= grant[0] ? PORT1 : PORT0;
        end
    end

    always_comb begin
        grant = '0;
        if (req == 2'b11) begin
            grant = (prio_q == PORT0) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a core port and a DMA port onto one single-cycle data memory
// with a fixed accept / strobe / response latency.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(BYTES_PER_WORD * MEM_WORDS);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        grant;
    logic              accept;
    port_t             port_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              addr_err;

    rr_arb2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({p1_req_valid, p0_req_valid}),
        .advance (accept),
        .grant   (grant)
    );

    assign accept   = p0_req_ready | p1_req_ready;
    assign addr_err = !is_aligned(addr_q[1:0]) || ({1'b0, addr_q} >= ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant != 2'b00) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            port_q      <= PORT0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                port_q  <= grant[1] ? PORT1 : PORT0;
                we_q    <= grant[1] ? p1_req_we    : p0_req_we;
                addr_q  <= grant[1] ? p1_req_addr  : p0_req_addr;
                wdata_q <= grant[1] ? p1_req_wdata : p0_req_wdata;
            end
            if (state_q == ACCESS) begin
                rsp_err_q   <= addr_err;
                rsp_rdata_q <= (!we_q && !addr_err) ? mem_read_data : '0;
            end
        end
    end

    // Every output is forced low while reset is held, even mid-transaction.
    always_comb begin
        p0_req_ready   = 1'b0;
        p1_req_ready   = 1'b0;
        p0_rsp_valid   = 1'b0;
        p0_rsp_rdata   = '0;
        p0_rsp_err     = 1'b0;
        p1_rsp_valid   = 1'b0;
        p1_rsp_rdata   = '0;
        p1_rsp_err     = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        busy           = 1'b0;
        if (reset_n) begin
            case (state_q)
                IDLE: begin
                    p0_req_ready = grant[0];
                    p1_req_ready = grant[1];
                end
                ACCESS: begin
                    busy           = 1'b1;
                    mem_address    = addr_q;
                    mem_write_data = wdata_q;
                    mem_read       = !we_q && !addr_err;
                    mem_write      = we_q && !addr_err;
                end
                RESP: begin
                    busy = 1'b1;
                    if (port_q == PORT0) begin
                        p0_rsp_valid = 1'b1;
                        p0_rsp_rdata = rsp_rdata_q;
                        p0_rsp_err   = rsp_err_q;
                    end else begin
                        p1_rsp_valid = 1'b1;
                        p1_rsp_rdata = rsp_rdata_q;
                        p1_rsp_err   = rsp_err_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-timeline model plus directed vectors.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req_valid, p0_req_ready, p0_req_we;
    logic [31:0] p0_req_addr, p0_req_wdata;
    logic        p0_rsp_valid, p0_rsp_err;
    logic [31:0] p0_rsp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we;
    logic [31:0] p1_req_addr, p1_req_wdata;
    logic        p1_rsp_valid, p1_rsp_err;
    logic [31:0] p1_rsp_rdata;
    logic        mem_read, mem_write, busy;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] env_mem   [256];
    logic [31:0] model_mem [256];

    dmem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_WORDS (256)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .p0_req_valid   (p0_req_valid),
        .p0_req_ready   (p0_req_ready),
        .p0_req_we      (p0_req_we),
        .p0_req_addr    (p0_req_addr),
        .p0_req_wdata   (p0_req_wdata),
        .p0_rsp_valid   (p0_rsp_valid),
        .p0_rsp_rdata   (p0_rsp_rdata),
        .p0_rsp_err     (p0_rsp_err),
        .p1_req_valid   (p1_req_valid),
        .p1_req_ready   (p1_req_ready),
        .p1_req_we      (p1_req_we),
        .p1_req_addr    (p1_req_addr),
        .p1_req_wdata   (p1_req_wdata),
        .p1_rsp_valid   (p1_rsp_valid),
        .p1_rsp_rdata   (p1_rsp_rdata),
        .p1_rsp_err     (p1_rsp_err),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory environment: combinational read, write on the strobe edge.
    assign mem_read_data = env_mem[mem_address[9:2]];
    always @(posedge clk) if (mem_write) env_mem[mem_address[9:2]] <= mem_write_data;

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i]   = 32'hC0DE0000 | i;
            model_mem[i] = 32'hC0DE0000 | i;
        end
        env_mem[2]   = 32'hA5;
        model_mem[2] = 32'hA5;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Transaction model: phase 0 waits for a request, 1 is the memory cycle, 2 the response.
    int          phase = 0;
    bit          pri = 1'b0;
    bit          t_port, t_we, t_err, g;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic        e_r0, e_r1, e_v0, e_v1, e_e0, e_e1, e_mr, e_mw, e_busy;
    logic [31:0] e_d0, e_d1, e_ma, e_mwd;

    always @(negedge clk) begin
        e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0; e_e0 = 0; e_e1 = 0;
        e_mr = 0; e_mw = 0; e_busy = 0; e_d0 = 0; e_d1 = 0; e_ma = 0; e_mwd = 0;
        if (reset_n !== 1'b1) begin
            phase = 0;
            pri   = 1'b0;
        end else if (phase == 0) begin
            if (p0_req_valid || p1_req_valid) begin
                g = (p0_req_valid && p1_req_valid) ? pri : p1_req_valid;
                if (g) e_r1 = 1; else e_r0 = 1;
                t_port  = g;
                t_we    = g ? p1_req_we    : p0_req_we;
                t_addr  = g ? p1_req_addr  : p0_req_addr;
                t_wdata = g ? p1_req_wdata : p0_req_wdata;
                t_err   = (t_addr[1:0] != 2'b00) || (t_addr >= 32'd1024);
                pri     = !g;
                phase   = 1;
            end
        end else if (phase == 1) begin
            e_busy  = 1;
            e_ma    = t_addr;
            e_mwd   = t_wdata;
            t_rdata = 0;
            if (!t_err) begin
                if (t_we) begin
                    e_mw = 1;
                    model_mem[t_addr[9:2]] = t_wdata;
                end else begin
                    e_mr    = 1;
                    t_rdata = model_mem[t_addr[9:2]];
                end
            end
            phase = 2;
        end else begin
            e_busy = 1;
            if (t_port) begin e_v1 = 1; e_d1 = t_rdata; e_e1 = t_err; end
            else        begin e_v0 = 1; e_d0 = t_rdata; e_e0 = t_err; end
            phase = 0;
        end
        check("cmp_p0_ready", p0_req_ready, e_r0);
        check("cmp_p1_ready", p1_req_ready, e_r1);
        check("cmp_p0_rsp_valid", p0_rsp_valid, e_v0);
        check("cmp_p0_rsp_rdata", p0_rsp_rdata, e_d0);
        check("cmp_p0_rsp_err", p0_rsp_err, e_e0);
        check("cmp_p1_rsp_valid", p1_rsp_valid, e_v1);
        check("cmp_p1_rsp_rdata", p1_rsp_rdata, e_d1);
        check("cmp_p1_rsp_err", p1_rsp_err, e_e1);
        check("cmp_mem_read", mem_read, e_mr);
        check("cmp_mem_write", mem_write, e_mw);
        check("cmp_mem_address", mem_address, e_ma);
        check("cmp_mem_write_data", mem_write_data, e_mwd);
        check("cmp_busy", busy, e_busy);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Deassert both requests and scramble their payloads.
    task automatic junk_inputs();
        p0_req_valid = 0; p0_req_we = 1; p0_req_addr = 32'h0000_0040; p0_req_wdata = 32'hBAD0_0000;
        p1_req_valid = 0; p1_req_we = 1; p1_req_addr = 32'h0000_0044; p1_req_wdata = 32'hBAD1_1111;
    endtask

    task automatic issue(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        junk_inputs();
        if (port) begin
            p1_req_valid = 1; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata;
        end else begin
            p0_req_valid = 1; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata;
        end
    endtask

    int gport[$];
    int gcyc[$];

    initial begin
        reset_n = 0;
        junk_inputs();
        p0_req_valid = 1;
        repeat (3) step();
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_p0_ready", p0_req_ready, 0);
        step();
        reset_n = 1;
        junk_inputs();
        step();

        // p0 read of 0x8
        issue(0, 0, 32'h8, 32'h0);
        @(negedge clk); check("rd8_ready", p0_req_ready, 1);
        step(); junk_inputs();
        @(negedge clk); check("rd8_mem_read", mem_read, 1); check("rd8_addr", mem_address, 32'h8);
        step();
        @(negedge clk); check("rd8_rsp_valid", p0_rsp_valid, 1); check("rd8_rdata", p0_rsp_rdata, 32'hA5);
        check("rd8_err", p0_rsp_err, 0);
        step();

        // p1 write of 0x1234 to the last word, then read it back via p0
        issue(1, 1, 32'h3FC, 32'h1234);
        @(negedge clk); check("wr_ready", p1_req_ready, 1);
        step(); junk_inputs();
        @(negedge clk); check("wr_mem_write", mem_write, 1); check("wr_wdata", mem_write_data, 32'h1234);
        step();
        @(negedge clk); check("wr_rsp_valid", p1_rsp_valid, 1); check("wr_rdata", p1_rsp_rdata, 0);
        check("wr_err", p1_rsp_err, 0);
        step();
        issue(0, 0, 32'h3FC, 32'h0);
        step(); junk_inputs(); step();
        @(negedge clk); check("rdback_rdata", p0_rsp_rdata, 32'h1234);
        step();

        // misaligned and out-of-range reads
        for (int k = 0; k < 2; k++) begin
            issue(0, 0, (k == 0) ? 32'h6 : 32'h400, 32'h0);
            step(); junk_inputs();
            @(negedge clk); check("err_no_rd", mem_read, 0); check("err_no_wr", mem_write, 0);
            step();
            @(negedge clk); check("err_flag", p0_rsp_err, 1); check("err_rdata", p0_rsp_rdata, 0);
            step();
        end

        // both ports requesting continuously after reset
        reset_n = 0; step(); step();
        reset_n = 1;
        p0_req_valid = 1; p0_req_we = 0; p0_req_addr = 32'h20; p0_req_wdata = 0;
        p1_req_valid = 1; p1_req_we = 0; p1_req_addr = 32'h24; p1_req_wdata = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (p0_req_ready) begin gport.push_back(0); gcyc.push_back(cyc); end
            if (p1_req_ready) begin gport.push_back(1); gcyc.push_back(cyc); end
            step();
        end
        junk_inputs();
        check("rr_grant_count", gport.size(), 4);
        if (gport.size() >= 4) begin
            for (int k = 0; k < 4; k++) check("rr_order", gport[k], k % 2);
            for (int k = 1; k < 4; k++) check("rr_spacing", gcyc[k] - gcyc[k-1], 3);
        end
        step(); step(); step();

        // reset during the memory cycle of a p1 write
        issue(1, 1, 32'h10, 32'hDEAD);
        @(negedge clk); check("abort_ready", p1_req_ready, 1);
        step(); junk_inputs(); reset_n = 0;
        @(negedge clk); check("abort_no_write", mem_write, 0);
        step(); reset_n = 1;
        @(negedge clk); check("abort_busy", busy, 0); check("abort_no_rsp", p1_rsp_valid, 0);
        step();
        @(negedge clk); check("abort_no_rsp2", p1_rsp_valid, 0);
        check("abort_mem_intact", env_mem[4], 32'hC0DE0004);
        step();

        // reset during a p0 access must return the tie priority to port 0
        issue(0, 0, 32'h30, 32'h0);
        @(negedge clk); check("ptr_pre_ready", p0_req_ready, 1);
        step(); junk_inputs(); reset_n = 0;
        step(); reset_n = 1;
        p0_req_valid = 1; p1_req_valid = 1; p0_req_we = 0; p1_req_we = 0;
        p0_req_addr = 32'h50; p1_req_addr = 32'h54;
        @(negedge clk); check("ptr_reset_p0", p0_req_ready, 1); check("ptr_reset_p1", p1_req_ready, 0);
        step(); junk_inputs();
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
